// File: rtl/seq_divider_32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : div_pkg
//  Description : Shared types and constants for the sequential signed divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    // Operand / result width of the divider datapath.
    localparam int DIV_W = 32;

    // Iteration counter width: enough to count DIV_W restoring steps.
    localparam int CNT_W = $clog2(DIV_W);

    // Controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_e;

endpackage
`default_nettype wire

// File: rtl/seq_divider_32_step.sv
`default_nettype none
// ============================================================================
//  Module      : div_step
//  Description : One combinational restoring-division iteration on unsigned
//                magnitudes: shift in a dividend bit, trial-subtract the
//                divisor, keep the difference when it does not go negative.
//  Revision    : 1.0 - initial release
// ============================================================================
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic [WIDTH-1:0] i_dvs,
    input  logic             i_bit,
    output logic [WIDTH:0]   o_rem,
    output logic             o_q_bit
);

    logic [WIDTH:0]   w_shift;
    logic [WIDTH+1:0] w_diff;
    logic             w_neg;

    // Shift, trial subtract, and restore on borrow.
    always_comb begin
        w_shift = {i_rem[WIDTH-1:0], i_bit};
        w_diff  = {1'b0, w_shift} - {2'b00, i_dvs};
        // A set top bit in the incoming remainder means the shifted value
        // already exceeds any WIDTH-bit divisor, so the subtraction succeeds.
        w_neg   = w_diff[WIDTH+1] & ~i_rem[WIDTH];
        o_q_bit = ~w_neg;
        o_rem   = w_neg ? w_shift : w_diff[WIDTH:0];
    end

endmodule
`default_nettype wire

// File: rtl/seq_divider_32.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider_32
//  Description : Iterative signed radix-2 restoring divider with valid/ready
//                request handshake. Produces a truncated quotient and a
//                remainder carrying the dividend's sign, plus divide-by-zero
//                and overflow flags, WIDTH+2 cycles after acceptance.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_divider_32
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    output logic             ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             div_by_zero,
    output logic             overflow,
    output logic             valid_out
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    div_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    // Holds |a| being shifted out at the top while quotient bits enter at the
    // bottom; after the last iteration it holds the quotient magnitude.
    logic [WIDTH-1:0] r_dq;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH:0]   r_prem;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_dz;

    logic [WIDTH:0]   w_next_rem;
    logic             w_q_bit;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem   (r_prem),
        .i_dvs   (r_dvs),
        .i_bit   (r_dq[WIDTH-1]),
        .o_rem   (w_next_rem),
        .o_q_bit (w_q_bit)
    );

    // Requests are taken only in IDLE and never while reset is asserted.
    assign ready = (r_state == IDLE) && !rst;

    // Controller, iteration datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_dq        <= '0;
            r_dvs       <= '0;
            r_prem      <= '0;
            r_sign_q    <= 1'b0;
            r_sign_r    <= 1'b0;
            r_dz        <= 1'b0;
            quot        <= '0;
            rem         <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            valid_out   <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (valid_in) begin
                        r_sign_q <= a[WIDTH-1] ^ b[WIDTH-1];
                        r_sign_r <= a[WIDTH-1];
                        r_prem   <= '0;
                        r_cnt    <= '0;
                        if (b == '0) begin
                            // Zero divisor skips the iterations entirely;
                            // the raw dividend becomes the remainder.
                            r_dz    <= 1'b1;
                            r_dq    <= a;
                            r_state <= FIX;
                        end else begin
                            r_dz    <= 1'b0;
                            r_dq    <= a[WIDTH-1] ? -a : a;
                            r_dvs   <= b[WIDTH-1] ? -b : b;
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_prem <= w_next_rem;
                    r_dq   <= {r_dq[WIDTH-2:0], w_q_bit};
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (r_cnt == c_LAST) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    valid_out <= 1'b1;
                    r_state   <= IDLE;
                    if (r_dz) begin
                        quot        <= '1;
                        rem         <= r_dq;
                        div_by_zero <= 1'b1;
                        overflow    <= 1'b0;
                    end else begin
                        quot        <= r_sign_q ? -r_dq : r_dq;
                        rem         <= r_sign_r ? -r_prem[WIDTH-1:0] : r_prem[WIDTH-1:0];
                        div_by_zero <= 1'b0;
                        // A positive quotient with magnitude 2^(WIDTH-1) is
                        // unrepresentable; only MIN / -1 reaches it.
                        overflow    <= ~r_sign_q & r_dq[WIDTH-1];
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
